// File: rtl/tag_check_stage.sv
// Tags host transmit words, holds one outstanding until a matching network acknowledge
// returns (retrying on timeout), and parity-checks every received network word.
module tag_check_stage #(
  parameter int data_size      = 32,
  parameter int tag_size       = 8,
  parameter int timeout_cycles = 16,
  parameter int max_retries    = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          host_valid_in,
  input  logic [data_size-1:0]          host_data_in,
  output logic                          host_ready_out,
  input  logic                          net_valid_in,
  input  logic [data_size+tag_size-1:0] net_word_in,
  input  logic                          net_parity_in,
  output logic                          net_ready_out,
  output logic [1:0]                    opcode_out,
  output logic                          soft_error_out,
  output logic [data_size-1:0]          tx_data_out,
  output logic [tag_size-1:0]           tx_tag_out,
  output logic [data_size+tag_size-1:0] tx_data_plus_tag_out,
  output logic                          tag_match_out,
  output logic [data_size-1:0]          rx_data_out,
  output logic [data_size+tag_size-1:0] ndt_out,
  output logic                          fail_out,
  output logic [1:0]                    state_dbg_out
);

  localparam int NW      = data_size + tag_size;
  localparam int TIMER_W = $clog2(timeout_cycles + 1);
  localparam int RETRY_W = (max_retries > 0) ? $clog2(max_retries + 1) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(timeout_cycles - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(max_retries);

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_TXE = 2'b01;
  localparam logic [1:0] OP_RXA = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_RETRY    = 2'd2
  } state_t;

  // Handshake: a word moves on any cycle where valid & ready are both high; ready is
  // derived from state and reset only, so it never depends on the valid it qualifies.

  state_t                 state_q, state_d;
  logic [tag_size-1:0]    tag_cnt_q, tag_cnt_d;
  logic [TIMER_W-1:0]     timer_q, timer_d;
  logic [RETRY_W-1:0]     retry_q, retry_d;
  logic [data_size-1:0]   tx_data_q, tx_data_d;
  logic [tag_size-1:0]    tx_tag_q, tx_tag_d;
  logic [data_size-1:0]   rx_data_q, rx_data_d;
  logic [NW-1:0]          ndt_q, ndt_d;
  logic [1:0]             opcode_q, opcode_d;
  logic                   soft_error_q, soft_error_d;
  logic                   tag_match_q, tag_match_d;
  logic                   fail_q, fail_d;
  logic                   pend_txe_q, pend_txe_d;

  logic                   host_fire;
  logic                   net_fire;
  logic                   perr;
  logic                   ack_match;
  logic                   txe_req;

  assign host_ready_out = (state_q == ST_IDLE) & ~reset;
  assign net_ready_out  = (state_q != ST_RETRY) & ~reset;

  assign host_fire = host_valid_in & host_ready_out;
  assign net_fire  = net_valid_in & net_ready_out;
  assign perr      = (^net_word_in) ^ net_parity_in;
  assign ack_match = net_fire & ~perr & (state_q == ST_WAIT_ACK) &
                     (net_word_in[tag_size-1:0] == tx_tag_q);

  always_comb begin
    state_d      = state_q;
    tag_cnt_d    = tag_cnt_q;
    timer_d      = timer_q;
    retry_d      = retry_q;
    tx_data_d    = tx_data_q;
    tx_tag_d     = tx_tag_q;
    rx_data_d    = rx_data_q;
    ndt_d        = ndt_q;
    opcode_d     = OP_NOP;
    soft_error_d = 1'b0;
    tag_match_d  = 1'b0;
    fail_d       = 1'b0;
    pend_txe_d   = 1'b0;
    txe_req      = pend_txe_q;

    case (state_q)
      ST_IDLE: begin
        if (host_fire) begin
          tx_data_d = host_data_in;
          tx_tag_d  = tag_cnt_q;
          tag_cnt_d = tag_cnt_q + 1'b1;
          timer_d   = '0;
          retry_d   = '0;
          state_d   = ST_WAIT_ACK;
          txe_req   = 1'b1;
        end
      end
      ST_WAIT_ACK: begin
        // A matching ack in the timeout cycle takes priority over the retry.
        if (ack_match) begin
          state_d = ST_IDLE;
        end else if (timer_q == TIMER_LAST) begin
          state_d = ST_RETRY;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_RETRY: begin
        if (retry_q < RETRY_MAX) begin
          retry_d = retry_q + 1'b1;
          timer_d = '0;
          state_d = ST_WAIT_ACK;
          txe_req = 1'b1;
        end else begin
          fail_d  = 1'b1;
          state_d = ST_IDLE;
          txe_req = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A received word owns the opcode slot; a colliding TXE is deferred one cycle
    // unless the ack it would announce has already arrived.
    if (net_fire) begin
      rx_data_d    = net_word_in[NW-1:tag_size];
      ndt_d        = net_word_in;
      opcode_d     = OP_RXA;
      soft_error_d = perr;
      tag_match_d  = ack_match;
      pend_txe_d   = txe_req & ~ack_match;
    end else if (txe_req) begin
      opcode_d = OP_TXE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      tag_cnt_q    <= '0;
      timer_q      <= '0;
      retry_q      <= '0;
      tx_data_q    <= '0;
      tx_tag_q     <= '0;
      rx_data_q    <= '0;
      ndt_q        <= '0;
      opcode_q     <= OP_NOP;
      soft_error_q <= 1'b0;
      tag_match_q  <= 1'b0;
      fail_q       <= 1'b0;
      pend_txe_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      tag_cnt_q    <= tag_cnt_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      tx_data_q    <= tx_data_d;
      tx_tag_q     <= tx_tag_d;
      rx_data_q    <= rx_data_d;
      ndt_q        <= ndt_d;
      opcode_q     <= opcode_d;
      soft_error_q <= soft_error_d;
      tag_match_q  <= tag_match_d;
      fail_q       <= fail_d;
      pend_txe_q   <= pend_txe_d;
    end
  end

  assign opcode_out           = opcode_q;
  assign soft_error_out       = soft_error_q;
  assign tx_data_out          = tx_data_q;
  assign tx_tag_out           = tx_tag_q;
  assign tx_data_plus_tag_out = {tx_data_q, tx_tag_q};
  assign tag_match_out        = tag_match_q;
  assign rx_data_out          = rx_data_q;
  assign ndt_out              = ndt_q;
  assign fail_out             = fail_q;
  assign state_dbg_out        = state_q;

endmodule

// File: tb/tb_tag_check_stage.sv
// Directed bench for tag_check_stage: expected output events are queued as stimulus is
// driven and compared when the registered outputs appear one cycle later.
module tb_tag_check_stage;

  localparam int DW = 32;
  localparam int TW = 8;
  localparam int NW = DW + TW;
  localparam int EW = 13;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          host_valid_in = 1'b0;
  logic [DW-1:0] host_data_in = '0;
  logic          host_ready_out;
  logic          net_valid_in = 1'b0;
  logic [NW-1:0] net_word_in = '0;
  logic          net_parity_in = 1'b0;
  logic          net_ready_out;
  logic [1:0]    opcode_out;
  logic          soft_error_out;
  logic [DW-1:0] tx_data_out;
  logic [TW-1:0] tx_tag_out;
  logic [NW-1:0] tx_data_plus_tag_out;
  logic          tag_match_out;
  logic [DW-1:0] rx_data_out;
  logic [NW-1:0] ndt_out;
  logic          fail_out;
  logic [1:0]    state_dbg_out;

  int n_vec = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];
  logic [TW-1:0] next_tag = '0;

  tag_check_stage dut (
    .clk                  (clk),
    .reset                (reset),
    .host_valid_in        (host_valid_in),
    .host_data_in         (host_data_in),
    .host_ready_out       (host_ready_out),
    .net_valid_in         (net_valid_in),
    .net_word_in          (net_word_in),
    .net_parity_in        (net_parity_in),
    .net_ready_out        (net_ready_out),
    .opcode_out           (opcode_out),
    .soft_error_out       (soft_error_out),
    .tx_data_out          (tx_data_out),
    .tx_tag_out           (tx_tag_out),
    .tx_data_plus_tag_out (tx_data_plus_tag_out),
    .tag_match_out        (tag_match_out),
    .rx_data_out          (rx_data_out),
    .ndt_out              (ndt_out),
    .fail_out             (fail_out),
    .state_dbg_out        (state_dbg_out)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timed out");
  end

  function automatic logic [EW-1:0] evt(input logic [1:0] op, input logic se,
                                        input logic tm, input logic fl,
                                        input logic [TW-1:0] tg);
    return {op, se, tm, fl, tg};
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input string name);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s: observed empty queue expected a queued event", name);
    end else begin
      e = exp_q.pop_front();
      chk(name, {opcode_out, soft_error_out, tag_match_out, fail_out, tx_tag_out}, e);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after an edge, results sampled 1 unit after the next.
  task automatic drive_host(input logic [DW-1:0] d);
    host_valid_in = 1'b1;
    host_data_in  = d;
    exp_q.push_back(evt(2'b01, 1'b0, 1'b0, 1'b0, next_tag));
    next_tag = next_tag + 1'b1;
    tick();
    host_valid_in = 1'b0;
    pop_check("txe_event");
    chk("tx_data", tx_data_out, d);
  endtask

  task automatic drive_net(input logic [TW-1:0] tg, input logic [DW-1:0] d,
                           input logic bad, input logic waiting,
                           input logic [TW-1:0] cur_tag);
    logic m;
    m = ~bad & waiting & (tg == cur_tag);
    net_valid_in  = 1'b1;
    net_word_in   = {d, tg};
    net_parity_in = (^{d, tg}) ^ bad;
    exp_q.push_back(evt(2'b10, bad, m, 1'b0, cur_tag));
    tick();
    net_valid_in = 1'b0;
    pop_check("rxa_event");
    chk("rx_data", rx_data_out, d);
    chk("ndt", ndt_out, {d, tg});
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_flags"}, {opcode_out, soft_error_out, tag_match_out, fail_out, state_dbg_out}, '0);
    chk({name, "_tx_dpt"}, tx_data_plus_tag_out, '0);
    chk({name, "_tx_data"}, tx_data_out, '0);
    chk({name, "_rx_data"}, rx_data_out, '0);
    chk({name, "_ndt"}, ndt_out, '0);
    chk({name, "_readies"}, {host_ready_out, net_ready_out}, 2'b00);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b0;
    exp_q.delete();
    next_tag = '0;
    #1;
    chk("ready_after_reset", {host_ready_out, net_ready_out}, 2'b11);
  endtask

  initial begin
    int retx;
    int rdy_low;
    int late_txe;
    bit got_fail;
    logic [DW-1:0] d;
    logic [TW-1:0] cur;

    // 1: reset, first host word
    do_reset();
    drive_host(32'hDEADBEEF);
    chk("t1_tag", tx_tag_out, 8'h00);
    chk("t1_dpt", tx_data_plus_tag_out, 40'hDEADBEEF00);
    chk("t1_host_ready", host_ready_out, 1'b0);

    // 2: matching ack returns to IDLE
    drive_net(8'h00, 32'h12345678, 1'b0, 1'b1, 8'h00);
    chk("t2_state", state_dbg_out, S_IDLE);
    chk("t2_host_ready", host_ready_out, 1'b1);

    // 3: wrong tag, then right tag with bad parity
    do_reset();
    drive_host(32'hCAFEF00D);
    drive_net(8'h05, 32'h0BADF00D, 1'b0, 1'b1, 8'h00);
    chk("t3_state_a", state_dbg_out, S_WAIT);
    drive_net(8'h00, 32'h0BADF00D, 1'b1, 1'b1, 8'h00);
    chk("t3_state_b", state_dbg_out, S_WAIT);

    // 4: no ack -> three retransmits with the same tag, then fail
    retx = 0;
    rdy_low = 0;
    got_fail = 1'b0;
    for (int i = 0; i < 200 && !got_fail; i++) begin
      tick();
      if (net_ready_out === 1'b0) rdy_low++;
      if (opcode_out === 2'b01) begin
        retx++;
        chk("t4_retx_tag", tx_tag_out, 8'h00);
      end
      if (fail_out === 1'b1) got_fail = 1'b1;
    end
    chk("t4_retx_count", retx, 3);
    chk("t4_fail_seen", got_fail, 1'b1);
    chk("t4_fail_opcode", opcode_out, 2'b00);
    chk("t4_retry_cycles", rdy_low, 4);
    chk("t4_host_ready", host_ready_out, 1'b1);
    tick();
    chk("t4_fail_pulse", fail_out, 1'b0);

    // 5: 257 acked transfers cover the tag wrap, then reset mid-WAIT_ACK
    do_reset();
    for (int i = 0; i < 257; i++) begin
      d = $urandom;
      cur = next_tag;
      drive_host(d);
      chk("t5_dpt", tx_data_plus_tag_out, {d, cur});
      drive_net(cur, $urandom, 1'b0, 1'b1, cur);
    end
    chk("t5_wrapped_tag", tx_tag_out, 8'h00);
    drive_host(32'h5555AAAA);
    chk("t5_tag_after_wrap", tx_tag_out, 8'h01);
    reset = 1'b1;
    tick();
    check_all_zero("t5_mid_reset");
    reset = 1'b0;
    exp_q.delete();
    next_tag = '0;

    // 6: ack lands in the timeout cycle -> no retransmit
    cur = next_tag;
    drive_host($urandom);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("t6_quiet", opcode_out, 2'b00);
    end
    drive_net(cur, $urandom, 1'b0, 1'b1, cur);
    chk("t6_state", state_dbg_out, S_IDLE);
    late_txe = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (opcode_out === 2'b01) late_txe++;
    end
    chk("t6_no_retx", late_txe, 0);

    // 7: host and net in the same IDLE cycle -> RXA first, TXE next
    cur = next_tag;
    d = 32'hA5A5_0F0F;
    host_valid_in = 1'b1;
    host_data_in  = d;
    net_valid_in  = 1'b1;
    net_word_in   = {32'h7777_1111, cur};
    net_parity_in = ^{32'h7777_1111, cur};
    exp_q.push_back(evt(2'b10, 1'b0, 1'b0, 1'b0, cur));
    exp_q.push_back(evt(2'b01, 1'b0, 1'b0, 1'b0, cur));
    next_tag = next_tag + 1'b1;
    tick();
    host_valid_in = 1'b0;
    net_valid_in  = 1'b0;
    pop_check("t7_rxa");
    chk("t7_tx_data", tx_data_out, d);
    tick();
    pop_check("t7_txe");
    chk("t7_state", state_dbg_out, S_WAIT);
    drive_net(cur, $urandom, 1'b0, 1'b1, cur);
    chk("t7_idle", state_dbg_out, S_IDLE);

    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
